// File: rtl/dstream_i2s_tx.sv
// Mono dstream sink to an I2S DAC: scale/saturate to SAMPLE_W, duplicate onto L/R, serialise. Optional I2S_HOLD_EN repeats the last word on underrun.
// Latency: an accepted sample is loaded at the next frame start; its MSB leaves one bclk after lrclk falls.
// Backpressure: x_rdy = !pend_valid straight from a register; the one-entry buffer empties at each frame load.
module dstream_i2s_tx #(
  parameter int W        = 32,
  parameter int W_FRAC   = 16,
  parameter int SAMPLE_W = 16,
  parameter int GAIN_SH  = 8,
  parameter int BCLK_DIV = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] x_dat,
  input  logic         x_vld,
  output logic         x_rdy,
  output logic         bclk,
  output logic         lrclk,
  output logic         sdata,
  output logic         underrun,
  output logic         sat
);

  localparam int FRAME_W = 2 * SAMPLE_W;
  localparam int BW      = $clog2(FRAME_W);
  localparam int DW      = $clog2(BCLK_DIV);
  localparam int SH      = W_FRAC - GAIN_SH;

  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_W - 1);
  localparam logic [BW-1:0] HALF     = BW'(SAMPLE_W);
  localparam logic [BW-1:0] FRAME_WB = BW'(FRAME_W);

  localparam logic signed [W-1:0] SAT_MAX = {{(W - SAMPLE_W + 1){1'b0}}, {(SAMPLE_W - 1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {{(W - SAMPLE_W + 1){1'b1}}, {(SAMPLE_W - 1){1'b0}}};

  logic [DW-1:0]         div_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [BW-1:0]         bit_nxt;
  logic [BW-1:0]         sel;
  logic [FRAME_W-1:0]    frame;
  logic [SAMPLE_W-1:0]   pend;
  logic [SAMPLE_W-1:0]   conv;
  logic                  pend_valid;
  logic                  accept;
  logic                  clip;
  logic                  div_wrap;
  logic                  fall_tick;
  logic signed [W-1:0]   shifted;

  assign x_rdy     = !pend_valid;
  assign accept    = x_vld && !pend_valid;
  assign div_wrap  = (div_cnt == DIV_LAST);
  assign fall_tick = div_wrap && bclk;
  assign bit_nxt   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
  // Bit index of frame word for slot k is FRAME_W-k; modular arithmetic keeps it in BW bits.
  assign sel       = FRAME_WB - bit_nxt;

  assign shifted = $signed(x_dat) >>> SH;

  always_comb begin
    conv = shifted[SAMPLE_W-1:0];
    clip = 1'b0;
    if (shifted > SAT_MAX) begin
      conv = SAT_MAX[SAMPLE_W-1:0];
      clip = 1'b1;
    end else if (shifted < SAT_MIN) begin
      conv = SAT_MIN[SAMPLE_W-1:0];
      clip = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      bit_cnt    <= BIT_LAST;
      bclk       <= 1'b0;
      lrclk      <= 1'b1;
      sdata      <= 1'b0;
      underrun   <= 1'b0;
      sat        <= 1'b0;
      pend       <= '0;
      pend_valid <= 1'b0;
      frame      <= '0;
    end else begin
      sat      <= accept && clip;
      underrun <= 1'b0;

      if (div_wrap) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (accept) begin
        pend       <= conv;
        pend_valid <= 1'b1;
      end

      if (fall_tick) begin
        bit_cnt <= bit_nxt;
        lrclk   <= (bit_nxt >= HALF);
        if (bit_nxt == '0) begin
          // Slot 0 still carries the LSB of the outgoing frame (one-bit I2S delay).
          sdata <= frame[0];
          // Load sees the pre-accept pend_valid, so a same-cycle accept waits a frame.
          if (pend_valid) begin
            frame      <= {pend, pend};
            pend_valid <= 1'b0;
          end else begin
            underrun <= 1'b1;
`ifdef I2S_HOLD_EN
            frame    <= frame;
`else
            frame    <= '0;
`endif
          end
        end else begin
          sdata <= frame[sel];
        end
      end
    end
  end

endmodule

// File: tb/tb_dstream_i2s_tx.sv
// Directed bench for dstream_i2s_tx: reset, clocking, scaling/saturation, back-to-back, underrun, mid-frame reset.
module tb_dstream_i2s_tx;

  logic        clk;
  logic        rst_n;
  logic [31:0] x_dat;
  logic        x_vld;
  logic        x_rdy;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        underrun;
  logic        sat;

  int nchecks;
  int nerrors;
  int urun_cnt;
  int sat_cnt;
  logic pb;
  logic pl;

  dstream_i2s_tx #(
    .W(32), .W_FRAC(16), .SAMPLE_W(16), .GAIN_SH(8), .BCLK_DIV(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .x_dat(x_dat), .x_vld(x_vld), .x_rdy(x_rdy),
    .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .underrun(underrun), .sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clk, sampled on the falling edge; pulse outputs are tallied here only.
  task automatic step();
    pb = bclk;
    pl = lrclk;
    @(negedge clk);
    if (underrun === 1'b1) urun_cnt++;
    if (sat === 1'b1) sat_cnt++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic sync_frame();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(pl === 1'b1 && lrclk === 1'b0) && n < 600);
    nchecks++;
    if (!(pl === 1'b1 && lrclk === 1'b0)) begin
      nerrors++;
      $display("FAIL sync_frame: no lrclk fall within %0d clk", n);
    end
  endtask

  // Starts at a frame boundary; returns the 32 bits shifted out and ends at the next boundary.
  task automatic get_frame(output logic [31:0] w, output int lr_err);
    logic exp_lr;
    int n;
    w = '0;
    lr_err = 0;
    for (int j = 1; j <= 32; j++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (!(pb === 1'b1 && bclk === 1'b0) && n < 20);
      if (!(pb === 1'b1 && bclk === 1'b0)) lr_err++;
      w = {w[30:0], sdata};
      exp_lr = ((j % 32) >= 16);
      if (lrclk !== exp_lr) lr_err++;
    end
  endtask

  task automatic feed(input logic [31:0] d);
    int n;
    n = 0;
    while (x_rdy !== 1'b1 && n < 600) begin
      step();
      n++;
    end
    x_dat = d;
    x_vld = 1'b1;
    step();
    x_vld = 1'b0;
    x_dat = 32'hDEAD_BEEF;
  endtask

  task automatic test_reset();
    int n;
    x_vld = 1'b0;
    x_dat = 32'h0;
    do_reset();
    nchecks++; if (bclk !== 1'b0) begin nerrors++; $display("FAIL reset_bclk: got %b expected 0", bclk); end
    nchecks++; if (lrclk !== 1'b1) begin nerrors++; $display("FAIL reset_lrclk: got %b expected 1", lrclk); end
    nchecks++; if (sdata !== 1'b0) begin nerrors++; $display("FAIL reset_sdata: got %b expected 0", sdata); end
    nchecks++; if (underrun !== 1'b0) begin nerrors++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
    nchecks++; if (sat !== 1'b0) begin nerrors++; $display("FAIL reset_sat: got %b expected 0", sat); end
    nchecks++; if (x_rdy !== 1'b1) begin nerrors++; $display("FAIL reset_x_rdy: got %b expected 1", x_rdy); end
    n = 0;
    do begin step(); n++; end while (bclk !== 1'b1 && n < 20);
    nchecks++; if (n != 4) begin nerrors++; $display("FAIL first_bclk_rise: at clk %0d expected 4", n); end
    do begin step(); n++; end while (lrclk !== 1'b0 && n < 40);
    nchecks++; if (n != 8) begin nerrors++; $display("FAIL first_lrclk_fall: at clk %0d expected 8", n); end
    nchecks++; if (underrun !== 1'b1) begin nerrors++; $display("FAIL first_underrun: got %b expected 1", underrun); end
  endtask

  task automatic test_idle();
    int u0, last, bad_div, highs;
    u0 = urun_cnt;
    last = 0;
    bad_div = 0;
    highs = 0;
    for (int i = 1; i <= 512; i++) begin
      step();
      if (bclk !== pb) begin
        if (i - last != 4) bad_div++;
        last = i;
      end
      if (sdata !== 1'b0) highs++;
    end
    nchecks++; if (urun_cnt - u0 != 2) begin nerrors++; $display("FAIL idle_underruns: got %0d expected 2", urun_cnt - u0); end
    nchecks++; if (bad_div != 0) begin nerrors++; $display("FAIL idle_bclk_period: %0d bad intervals expected 0", bad_div); end
    nchecks++; if (highs != 0) begin nerrors++; $display("FAIL idle_sdata: %0d high samples expected 0", highs); end
  endtask

  task automatic test_basic();
    logic [31:0] w;
    int lr_err, u0;
    x_dat = 32'h0064_0000;
    x_vld = 1'b1;
    do_reset();
    u0 = urun_cnt;
    step();
    nchecks++; if (x_rdy !== 1'b0) begin nerrors++; $display("FAIL basic_accept: x_rdy got %b expected 0", x_rdy); end
    x_vld = 1'b0;
    x_dat = 32'hDEAD_BEEF;
    sync_frame();
    nchecks++; if (urun_cnt != u0) begin nerrors++; $display("FAIL basic_no_underrun: got %0d expected 0", urun_cnt - u0); end
    get_frame(w, lr_err);
    nchecks++; if (w !== 32'h6400_6400) begin nerrors++; $display("FAIL basic_word: got %h expected 64006400", w); end
    nchecks++; if (lr_err != 0) begin nerrors++; $display("FAIL basic_lrclk_framing: %0d errors expected 0", lr_err); end
  endtask

  task automatic test_scaling();
    logic [31:0] din  [4] = '{32'h0080_0000, 32'hFF7F_0000, 32'hFF80_0000, 32'hFFFF_FF80};
    logic [31:0] wexp [4] = '{32'h7FFF_7FFF, 32'h8000_8000, 32'h8000_8000, 32'hFFFF_FFFF};
    int          sexp [4] = '{1, 1, 0, 0};
    logic [31:0] w;
    int lr_err, s0;
    for (int i = 0; i < 4; i++) begin
      s0 = sat_cnt;
      feed(din[i]);
      sync_frame();
      get_frame(w, lr_err);
      nchecks++; if (w !== wexp[i]) begin nerrors++; $display("FAIL scale_word[%0d]: got %h expected %h", i, w, wexp[i]); end
      nchecks++; if (sat_cnt - s0 != sexp[i]) begin nerrors++; $display("FAIL scale_sat[%0d]: got %0d pulses expected %0d", i, sat_cnt - s0, sexp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] samp [3] = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000};
    logic [31:0] wexp [3] = '{32'h0100_0100, 32'h0200_0200, 32'h0300_0300};
    logic [31:0] words [4];
    int lr_errs [4];
    int rdy_err, u0, lr_tot;
    logic plr;
    rdy_err = 0;
    u0 = urun_cnt;
    fork
      begin
        for (int f = 0; f < 4; f++) get_frame(words[f], lr_errs[f]);
      end
      begin
        for (int i = 0; i < 3; i++) begin
          int n;
          x_dat = samp[i];
          x_vld = 1'b1;
          n = 0;
          while (x_rdy !== 1'b1 && n < 600) begin
            plr = lrclk;
            @(negedge clk);
            n++;
            if (x_rdy === 1'b1 && !(plr === 1'b1 && lrclk === 1'b0)) rdy_err++;
          end
          if (x_rdy !== 1'b1) rdy_err++;
          @(negedge clk);
          if (x_rdy !== 1'b0) rdy_err++;
        end
        x_vld = 1'b0;
        x_dat = 32'hDEAD_BEEF;
      end
    join
    lr_tot = lr_errs[1] + lr_errs[2] + lr_errs[3];
    for (int i = 0; i < 3; i++) begin
      nchecks++; if (words[i+1] !== wexp[i]) begin nerrors++; $display("FAIL b2b_word[%0d]: got %h expected %h", i, words[i+1], wexp[i]); end
    end
    nchecks++; if (rdy_err != 0) begin nerrors++; $display("FAIL b2b_ready: %0d handshake errors expected 0", rdy_err); end
    nchecks++; if (urun_cnt - u0 != 1) begin nerrors++; $display("FAIL b2b_underruns: got %0d expected 1", urun_cnt - u0); end
    nchecks++; if (lr_tot != 0) begin nerrors++; $display("FAIL b2b_lrclk_framing: %0d errors expected 0", lr_tot); end
  endtask

  task automatic test_stop();
    logic [31:0] w0, w1, exp_idle;
    int lr_err, u0;
`ifdef I2S_HOLD_EN
    exp_idle = 32'h3200_3200;
`else
    exp_idle = 32'h0000_0000;
`endif
    feed(32'h0032_0000);
    sync_frame();
    u0 = urun_cnt;
    get_frame(w0, lr_err);
    get_frame(w1, lr_err);
    nchecks++; if (w0 !== 32'h3200_3200) begin nerrors++; $display("FAIL stop_last_word: got %h expected 32003200", w0); end
    nchecks++; if (w1 !== exp_idle) begin nerrors++; $display("FAIL stop_idle_word: got %h expected %h", w1, exp_idle); end
    nchecks++; if (urun_cnt - u0 != 2) begin nerrors++; $display("FAIL stop_underruns: got %0d expected 2", urun_cnt - u0); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    int lr_err, u0, n;
    feed(32'h0012_0000);
    sync_frame();
    feed(32'h0055_0000);
    n = 0;
    while (lrclk !== 1'b1 && n < 600) begin step(); n++; end
    nchecks++; if (x_rdy !== 1'b0) begin nerrors++; $display("FAIL mid_pending: x_rdy got %b expected 0", x_rdy); end
    rst_n = 1'b0;
    step();
    nchecks++; if (bclk !== 1'b0) begin nerrors++; $display("FAIL mid_bclk: got %b expected 0", bclk); end
    nchecks++; if (lrclk !== 1'b1) begin nerrors++; $display("FAIL mid_lrclk: got %b expected 1", lrclk); end
    nchecks++; if (sdata !== 1'b0) begin nerrors++; $display("FAIL mid_sdata: got %b expected 0", sdata); end
    nchecks++; if (underrun !== 1'b0) begin nerrors++; $display("FAIL mid_underrun: got %b expected 0", underrun); end
    nchecks++; if (sat !== 1'b0) begin nerrors++; $display("FAIL mid_sat: got %b expected 0", sat); end
    nchecks++; if (x_rdy !== 1'b1) begin nerrors++; $display("FAIL mid_x_rdy: got %b expected 1", x_rdy); end
    rst_n = 1'b1;
    u0 = urun_cnt;
    sync_frame();
    nchecks++; if (urun_cnt - u0 != 1) begin nerrors++; $display("FAIL mid_underrun_after: got %0d expected 1", urun_cnt - u0); end
    get_frame(w, lr_err);
    nchecks++; if (w !== 32'h0) begin nerrors++; $display("FAIL mid_discarded: got %h expected 00000000", w); end
  endtask

  initial begin
    nchecks = 0;
    nerrors = 0;
    urun_cnt = 0;
    sat_cnt = 0;
    pb = 1'b0;
    pl = 1'b0;
    rst_n = 1'b0;
    x_vld = 1'b0;
    x_dat = 32'h0;
    test_reset();
    test_idle();
    test_basic();
    test_scaling();
    test_back_to_back();
    test_stop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/dstream_i2s_tx.md
Name: dstream_i2s_tx

Overview:
- Sink end of the audio dstream chain. Takes filtered Q(W-W_FRAC).W_FRAC samples (e.g. `low_pass_conv` output `y`) and drives a mono stream to an I2S DAC.
- Scales and saturates each sample to SAMPLE_W bits and serialises it onto both I2S channels.
- Generates bclk/lrclk from the system clock.
- Applies backpressure through x.ready via a one-entry holding buffer.

Parameters:
- W, 32, input sample width (two's complement fixed point)
- W_FRAC, 16, input fractional bits
- SAMPLE_W, 16, I2S word width per channel
- GAIN_SH, 8, left shift applied to the integer part; must satisfy 0 <= GAIN_SH <= W_FRAC
- BCLK_DIV, 4, clk cycles per bclk half-period; must be >= 2

Ports:
- clk, input, 1, system clock, all logic on posedge
- rst_n, input, 1, synchronous active-low reset
- x, dstream sink (data in, valid in, ready out), W, input sample stream
- bclk, output, 1, I2S bit clock
- lrclk, output, 1, I2S word select (0 = left, 1 = right)
- sdata, output, 1, I2S serial data
- underrun, output, 1, one-clk pulse when a frame starts with no sample buffered
- sat, output, 1, one-clk pulse when an accepted sample was clipped

Behaviour:
- Reset (rst_n=0 at posedge):
  - Outputs: bclk=0, lrclk=1, sdata=0, underrun=0, sat=0.
  - Counters: div_cnt=0, bit_cnt=2*SAMPLE_W-1.
  - Buffer: pend_valid=0, frame word=0.
  - Reset mid-frame aborts the frame immediately; the buffered sample is discarded.
- Handshake:
  - x.ready = !pend_valid, driven directly from the register.
  - A sample is accepted at a posedge with x.valid && x.ready.
  - x.data is ignored when not accepted.
  - No combinational path exists from x.valid to x.ready.
- Conversion at accept:
  - s = x.data >>> (W_FRAC - GAIN_SH), arithmetic shift (floor).
  - Clamp s to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
  - Store the SAMPLE_W result in pend and set pend_valid.
  - sat pulses on the following cycle if clamping occurred.
- Clock generation:
  - div_cnt counts 0..BCLK_DIV-1.
  - At div_cnt==BCLK_DIV-1, bclk toggles and div_cnt returns to 0.
  - A "fall tick" is a toggle with bclk==1.
- At each fall tick, bit_cnt advances modulo 2*SAMPLE_W.
  - lrclk = (new bit_cnt >= SAMPLE_W); lrclk changes on the bclk falling edge.
- Frame load, at the fall tick where bit_cnt wraps to 0:
  - If pend_valid: frame word <= {pend, pend} (left and right identical) and pend_valid <= 0.
  - Otherwise: frame word <= 0 and underrun pulses for one clk.
- Serialisation (standard I2S one-bit delay):
  - At the fall tick to bit_cnt=k (k>=1), sdata <= frame word bit (2*SAMPLE_W-k), MSB first.
  - At bit_cnt=0, sdata <= LSB of the previous frame's right word (0 after reset).
- Same-cycle accept and frame load: the load sees the old pend_valid, which is 0 because ready implies empty. That frame is therefore an underrun; the new sample is held for the next frame. There is no bypass path.
- Timing at defaults:
  - Frame period = 4*SAMPLE_W*BCLK_DIV clk = 256 clk.
  - First fall tick occurs 2*BCLK_DIV clk after reset release.
  - Steady-state throughput is one sample per frame.

Optional Feature:
- Macro I2S_HOLD_EN.
- Defined: on underrun the frame word keeps its previous value, so the last sample repeats. underrun still pulses.
- Undefined: on underrun the frame word is zero (silence).

Test Plan:
- Reset, hold x.valid=0 → bclk toggles every 4 clk. lrclk falls at the first fall tick (clk 8 after release). underrun pulses every 256 clk. sdata stays 0.
- Present x.data=0x0064_0000 before the first frame load → left and right words both serialise 0x6400 MSB-first. MSB appears one bclk after lrclk falls; lrclk rises between the two words.
- x.data=0x0080_0000 → word 0x7FFF and sat pulses once. x.data=0xFF7F_0000 → word 0x8000 with sat. x.data=0xFF80_0000 → word 0x8000 without sat.
- Continuous x.valid=1 with samples 0x0001_0000, 0x0002_0000, 0x0003_0000 → x.ready drops after each accept and rises at the next frame load. Words 0x0100, 0x0200, 0x0300 appear in order; no underrun after the first frame.
- Stop input after 0x0032_0000 → next frame is 0x0000 (or 0x3200 with I2S_HOLD_EN defined) and underrun pulses.
- Assert rst_n=0 mid-right-word with pend_valid=1 → all outputs return to reset values next clk. x.ready=1 after release. The discarded sample never appears on sdata.
